// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with a multi-cycle multiplier and bit-serial restoring divider.
// Decodes MIPS R-type HI/LO instructions and stalls the E stage while MUL/DIV is in flight.
module hilo_muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [31:0]      instr_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hilo_rd_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  localparam int CNT_MAX = (WIDTH > MUL_STAGES) ? WIDTH : MUL_STAGES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   a_q, b_q, rem_q, hi_q, lo_q;
  logic               done_q, sgn_q, qneg_q, rneg_q, dz_q;

  logic [5:0]         funct;
  logic               is_r, accept, dec_mul, dec_div, dec_mthi, dec_mtlo;
  logic               unused_bits;

  assign funct       = instr_i[5:0];
  assign is_r        = (instr_i[31:26] == 6'b000000);
  assign unused_bits = ^instr_i[25:6];
  assign accept      = (state_q == S_IDLE) && valid_i && !flush_i && is_r;
  assign dec_mul     = accept && (funct == F_MULT || funct == F_MULTU);
  assign dec_div     = accept && (funct == F_DIV  || funct == F_DIVU);
  assign dec_mthi    = accept && (funct == F_MTHI);
  assign dec_mtlo    = accept && (funct == F_MTLO);

  // Signed DIV works on magnitudes; signs are reapplied in the fix-up cycle.
  logic               div_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  assign div_signed = (funct == F_DIV);
  assign a_mag = (div_signed && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag = (div_signed && b_i[WIDTH-1]) ? -b_i : b_i;

  logic [WIDTH:0]     rem_sh, rem_sub;
  logic               ge;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign rem_sh  = {rem_q, a_q[WIDTH-1]};
  assign rem_sub = rem_sh - {1'b0, b_q};
  assign ge      = (rem_sh >= {1'b0, b_q});
  assign quo_fix = dz_q ? '1 : (qneg_q ? -a_q : a_q);
  assign rem_fix = rneg_q ? -rem_q : rem_q;

  logic [2*WIDTH-1:0] mul_ax, mul_bx, prod;
  assign mul_ax = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign mul_bx = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign prod   = mul_ax * mul_bx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (dec_mul)      state_d = S_MUL;
        else if (dec_div) state_d = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (flush_i || cnt_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_o   = (state_q != S_IDLE);
    hilo_rd_o = '0;
    if (state_q == S_IDLE && valid_i && is_r) begin
      if (funct == F_MFHI)      hilo_rd_o = hi_q;
      else if (funct == F_MFLO) hilo_rd_o = lo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rem_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      sgn_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (dec_mthi) hi_q <= a_i;
          if (dec_mtlo) lo_q <= a_i;
          if (dec_mul) begin
            a_q   <= a_i;
            b_q   <= b_i;
            sgn_q <= (funct == F_MULT);
            cnt_q <= CW'(MUL_STAGES - 1);
          end
          if (dec_div) begin
            a_q    <= a_mag;
            b_q    <= b_mag;
            rem_q  <= '0;
            qneg_q <= div_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            rneg_q <= div_signed && a_i[WIDTH-1];
            dz_q   <= (b_i == '0);
            cnt_q  <= CW'(WIDTH);
          end
        end
        S_MUL: if (!flush_i) begin
          if (cnt_q == '0) begin
            {hi_q, lo_q} <= prod;
            done_q       <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DIV: if (!flush_i) begin
          if (cnt_q != '0) begin
            rem_q <= ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            a_q   <= {a_q[WIDTH-2:0], ge};
            cnt_q <= cnt_q - 1'b1;
          end else begin
            hi_q   <= rem_fix;
            lo_q   <= quo_fix;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench: stimulus pushes expected {HI,LO} per MUL/DIV; a monitor pops on done_o.
module tb_hilo_muldiv_unit;
  localparam int W  = 32;
  localparam int MS = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_i;
  logic [31:0]  instr_i;
  logic [W-1:0] a_i, b_i;
  logic         flush_i;
  logic         stall_o, done_o;
  logic [W-1:0] hilo_rd_o, hi_o, lo_o;

  hilo_muldiv_unit #(.WIDTH(W), .MUL_STAGES(MS)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .instr_i(instr_i),
    .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .stall_o(stall_o),
    .done_o(done_o), .hilo_rd_o(hilo_rd_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    bit           chk_rd;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_done: done_o=1 with nothing outstanding");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_hi"}, hi_o, e.hi);
        check({e.name, "_lo"}, lo_o, e.lo);
        if (e.chk_rd) check({e.name, "_mflo_rd"}, hilo_rd_o, e.lo);
      end
    end
  end

  function automatic logic [31:0] rtype(input logic [5:0] f);
    return {6'b000000, 20'd0, f};
  endfunction

  task automatic push(input logic [W-1:0] hi, input logic [W-1:0] lo, input bit rd, input string name);
    exp_t e;
    e.hi = hi; e.lo = lo; e.chk_rd = rd; e.name = name;
    exp_q.push_back(e);
  endtask

  // Present one instruction for a single cycle, then count busy cycles.
  task automatic op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                    input int busy, input string name);
    int n;
    valid_i = 1'b1; instr_i = rtype(f); a_i = a; b_i = b;
    @(posedge clk); #1;
    valid_i = 1'b0; instr_i = '0;
    n = 0;
    while (stall_o && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    check({name, "_busy"}, W'(n), W'(busy));
  endtask

  task automatic read_chk(input logic [5:0] f, input logic [W-1:0] exp, input string name);
    valid_i = 1'b1; instr_i = rtype(f);
    #1;
    check(name, hilo_rd_o, exp);
    @(posedge clk); #1;
    valid_i = 1'b0; instr_i = '0;
  endtask

  initial begin
    int n;
    rst = 1'b1; valid_i = 1'b1; instr_i = rtype(6'h10); a_i = '0; b_i = '0; flush_i = 1'b0;
    #2;
    check("rst_stall", W'(stall_o), 0);
    check("rst_done", W'(done_o), 0);
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    check("rst_rd", hilo_rd_o, 0);
    valid_i = 1'b0; instr_i = '0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    op(6'h11, 32'h12345678, 0, 0, "mthi");
    op(6'h13, 32'hCAFEBABE, 0, 0, "mtlo");
    read_chk(6'h10, 32'h12345678, "mfhi");
    read_chk(6'h12, 32'hCAFEBABE, "mflo");

    push(32'hFFFFFFFF, 32'hFFFFFFFA, 0, "mult");
    op(6'h18, 32'hFFFFFFFE, 3, MS, "mult");
    push(32'h00000002, 32'hFFFFFFFA, 0, "multu");
    op(6'h19, 32'hFFFFFFFE, 3, MS, "multu");
    push(32'hFFFFFFFF, 32'hFFFFFFFD, 0, "div_neg");
    op(6'h1A, 32'hFFFFFFF9, 2, W + 1, "div_neg");
    push(32'h00000001, 32'hFFFFFFFD, 0, "div_negb");
    op(6'h1A, 7, 32'hFFFFFFFE, W + 1, "div_negb");
    push(32'h00000001, 32'h00000003, 0, "divu");
    op(6'h1B, 7, 2, W + 1, "divu");
    push(32'h00000005, 32'hFFFFFFFF, 0, "divu_z");
    op(6'h1B, 5, 0, W + 1, "divu_z");
    push(32'h00000000, 32'h80000000, 0, "div_ovf");
    op(6'h1A, 32'h80000000, 32'hFFFFFFFF, W + 1, "div_ovf");

    // MFLO held upstream through the MULT stall, observed in the done cycle.
    push(32'h00000000, 32'h00000006, 1, "mult_hold");
    valid_i = 1'b1; instr_i = rtype(6'h18); a_i = 32'hFFFFFFFE; b_i = 32'hFFFFFFFD;
    @(posedge clk); #1;
    instr_i = rtype(6'h12);
    n = 0;
    while (stall_o && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    check("mult_hold_busy", W'(n), W'(MS));
    @(posedge clk); #1;
    valid_i = 1'b0; instr_i = '0;

    // Non-R-type op with an MTHI funct must be ignored.
    valid_i = 1'b1; instr_i = {6'b000001, 20'd0, 6'h11}; a_i = 32'hDEADBEEF;
    @(posedge clk); #1;
    valid_i = 1'b0; instr_i = '0;
    check("nonr_hi", hi_o, 32'h00000000);
    check("nonr_stall", W'(stall_o), 0);

    // Flush in busy cycle 10 of a DIVU.
    op(6'h11, 32'hA5A5A5A5, 0, 0, "pre_hi");
    op(6'h13, 32'hA5A5A5A5, 0, 0, "pre_lo");
    valid_i = 1'b1; instr_i = rtype(6'h1B); a_i = 100; b_i = 7;
    @(posedge clk); #1;
    valid_i = 1'b0; instr_i = '0;
    repeat (9) begin @(posedge clk); #1; end
    check("flush_pre_stall", W'(stall_o), 1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush_stall", W'(stall_o), 0);
    check("flush_hi", hi_o, 32'hA5A5A5A5);
    check("flush_lo", lo_o, 32'hA5A5A5A5);
    repeat (40) @(posedge clk);
    #1;
    check("flush_lo_late", lo_o, 32'hA5A5A5A5);

    // Async reset in the middle of a MULT.
    valid_i = 1'b1; instr_i = rtype(6'h19); a_i = 3; b_i = 5;
    @(posedge clk); #1;
    valid_i = 1'b0; instr_i = '0;
    check("rmid_busy", W'(stall_o), 1);
    #2 rst = 1'b1;
    #1;
    check("rmid_stall", W'(stall_o), 0);
    check("rmid_hi", hi_o, 0);
    check("rmid_lo", lo_o, 0);
    @(negedge clk); rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    check("pending_ops", W'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Multi-cycle multiply/divide unit with an integrated HI/LO register pair for the MIPS execute stage. It decodes R-type MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the instruction word and runs a configurable-latency multiplier and a bit-serial restoring divider. It owns the HI/LO state and stalls the pipeline while an operation is in flight. It sits beside the ALU and replaces the single-cycle HI/LO path of the ALU decoder.

## Interface
- WIDTH, 32, datapath width of rs, rt, HI and LO.
- MUL_STAGES, 2, busy cycles for MULT/MULTU; must be ≥1.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- valid_i  in  1  instr_i/a_i/b_i hold a live E-stage instruction
- instr_i  in  32  instruction word; op=[31:26], funct=[5:0]
- a_i  in  WIDTH  rs value (dividend / multiplicand / MTHI-MTLO source)
- b_i  in  WIDTH  rt value (divisor / multiplier)
- flush_i  in  1  abort any in-flight operation; blocks acceptance this cycle
- stall_o  out  1  unit busy; upstream must hold E stage
- done_o  out  1  one-cycle pulse, HI/LO just updated by MUL/DIV
- hilo_rd_o  out  WIDTH  HI for MFHI, LO for MFLO, 0 otherwise (combinational)
- hi_o, lo_o  out  WIDTH  current HI/LO registers

## Operation
- Decode applies only when op=6'b000000. funct values: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B. Any other op/funct is ignored with no state change.
- States: IDLE, MUL, DIV. stall_o = (state != IDLE), decoded from state only.
- Acceptance requires IDLE & valid_i & !flush_i. valid_i in MUL/DIV is ignored.
- MTHI/MTLO: HI (resp. LO) <= a_i at the accept edge; no busy cycles.
- MFHI/MFLO: read only; hilo_rd_o reflects the registers.
- MULT/MULTU: a_i and b_i are latched at accept and the unit enters MUL with counter = MUL_STAGES-1. Counter decrements each cycle. On the cycle counter=0, the edge writes {HI,LO} = 2·WIDTH product (signed for MULT, unsigned for MULTU) and the state returns to IDLE.
- DIV/DIVU: the unit latches magnitudes (DIVU: raw values) and the signs, then enters DIV. It runs WIDTH restoring iterations, one quotient bit per cycle, followed by one fix-up cycle.
  - Fix-up for DIV: quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
  - LO = quotient, HI = remainder.
- Divisor zero: HI = a_i and LO = all ones. The operation completes with normal latency.
- DIV 0x80000000 / -1: LO = 0x80000000, HI = 0 (natural wrap).
- flush_i in MUL/DIV: next edge goes to IDLE, HI/LO unchanged, no done_o. If flush_i lands on the completion edge, flush wins.
- Reset (async): state IDLE, HI=LO=0, counters 0, latched operands 0, done_o=0. Hence stall_o=0, hi_o=lo_o=0 and hilo_rd_o=0 (or HI/LO=0) immediately.

## Timing
- Accept edge ends cycle T0; stall_o is low in T0.
- MUL: stall_o is high for exactly MUL_STAGES cycles; HI/LO are updated at the edge ending the last of them.
- DIV: stall_o is high for exactly WIDTH+1 cycles (WIDTH iterations plus fix-up).
- done_o is registered: high for one cycle, the first IDLE cycle after the write. In that same cycle, an MFHI/MFLO held on instr_i sees the new value on hilo_rd_o.
- An instruction held upstream while stall_o is high is accepted in the first IDLE cycle. Back-to-back MUL/DIV therefore has zero idle gap beyond the done cycle.
- MTHI/MTLO take effect at their accept edge; an MFHI/MFLO in the next cycle reads the new value.

## Test plan
- MTHI a_i=0x12345678, MTLO a_i=0xCAFEBABE, then MFHI -> hilo_rd_o=0x12345678; MFLO -> 0xCAFEBABE; stall_o never high.
- MULT a=0xFFFFFFFE, b=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA. stall_o high exactly MUL_STAGES cycles; done_o pulses once.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1. stall_o high exactly 33 cycles.
- DIVU 5/0 -> HI=5, LO=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload HI=LO=0xA5A5A5A5, start DIVU, assert flush_i in busy cycle 10 -> stall_o low the next cycle, HI/LO still 0xA5A5A5A5, no done_o. Async rst mid-MUL -> hi_o=lo_o=0 and stall_o=0 before the next edge.
- MULT followed by MFLO held on instr_i with valid_i during stall -> MFLO ignored while busy; in the done_o cycle hilo_rd_o equals the new LO.
